cipher_uart_ctrl: RTL and testbench
===================================

# cipher_uart_ctrl

Parametrised command/response controller between a byte-wide UART receiver/transmitter pair and a bank of lightweight block-cipher cores (SIMON, SPECK, ...). It parses a command byte, collects KEY_BYTES key bytes and BLK_BYTES block bytes, starts the selected core, captures its result and streams it back byte by byte through the UART transmitter. Compared with the single-cipher controller, it adds:
- cipher selection;
- key reuse;
- an inter-byte timeout;
- an error response.

## Interface
Parameters:
- KEY_BYTES, 8, key length in bytes (≥1).
- BLK_BYTES, 4, block length in bytes (≥1).
- N_CIPHERS, 2, number of attached cores (1..8).
- TIMEOUT_CYCLES, 100000, inter-byte receive timeout in clk cycles (≥2).
- ERR_CODE, 8'hEE, byte sent on error.

Ports:
- clk  in  1  clock, all logic on rising edge.
- resetn  in  1  reset, asynchronous, active-high.
- rx_byte  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe, rx_byte valid.
- tx_byte  out  8  byte to UART transmitter.
- tx_valid  out  1  one-cycle load strobe to transmitter.
- tx_busy  in  1  transmitter active.
- tx_done  in  1  one-cycle strobe, byte transmission finished.
- cipher_sel  out  3  selected core index.
- decrypt  out  1  1 = decrypt, 0 = encrypt.
- start  out  1  one-cycle start pulse to the selected core.
- key_out  out  8*KEY_BYTES  key, byte i at bits [8i+7:8i].
- text_out  out  8*BLK_BYTES  input block, same packing.
- result_in  in  8*BLK_BYTES  result from the selected core.
- result_valid  in  1  one-cycle strobe, result_in valid.
- state_led  out  5  one-hot: CMD, KEY, TEXT, WAIT, TX.
- err  out  1  sticky error flag, cleared by the next valid command.

## Operation
Command byte:
- bit0 = decrypt.
- bits[3:1] = cipher index.
- bit7 = key reuse: skip the KEY state and keep the previous key_out.
- bits[6:4] are ignored.

Byte order: the first received byte fills byte 0 (LSB); subsequent bytes fill ascending indices. Transmission is also byte 0 first.

States:
- CMD: wait for rx_valid.
  - Index ≥ N_CIPHERS → ERR.
  - Otherwise latch cipher_sel/decrypt, clear err, go to KEY (bit7=0) or TEXT (bit7=1).
- KEY: store bytes at a counter index. After byte KEY_BYTES-1 → TEXT.
- TEXT: store bytes likewise. After byte BLK_BYTES-1 → START.
- START: assert start for one cycle → WAIT.
- WAIT: on result_valid, capture result_in into the result register → TX.
- TX: for each byte, wait for tx_busy=0, then pulse tx_valid with tx_byte = result byte n, then wait for tx_done. After byte BLK_BYTES-1 → CMD.
- ERR: set err; send ERR_CODE once using the TX handshake → CMD.

Rules:
- rx_valid is ignored in START, WAIT, TX and ERR; bytes received there are dropped.
- result_valid outside WAIT is ignored.
- Timeout: in KEY or TEXT, a counter resets on each rx_valid. If it reaches TIMEOUT_CYCLES → ERR. Partially received bytes are discarded, and key_out/text_out keep their written contents.
- A reset while in any state returns the block to CMD, clears all registers and aborts any pending transmission request.

## Timing
- Reset values: tx_byte=0, tx_valid=0, cipher_sel=0, decrypt=0, start=0, key_out=0, text_out=0, err=0, state_led=5'b00001.
- The state advances in the cycle after the sampled rx_valid. The stored byte is visible on key_out/text_out one cycle after rx_valid.
- start is high exactly 1 cycle, 2 cycles after the last text rx_valid.
- tx_valid is asserted no earlier than 1 cycle after tx_busy is sampled low. tx_byte is stable from tx_valid until tx_done.
- The next tx_valid comes ≥1 cycle after tx_done.
- Back-to-back rx_valid on consecutive cycles must be accepted without loss.
- If rx_valid coincides with the timeout expiry, the byte wins and the counter restarts.

## Test plan
- Encrypt, cipher 0: send 01, then key 00 01 08 09 10 11 18 19, then text 65 65 77 68.
  - key_out=64'h1918111009080100, text_out=32'h68776565, decrypt=0.
  - One start pulse.
  - Model returns 32'he9bbc69b → tx bytes 9b c6 bb e9, in order.
- Key reuse: after the first test, send 83 then 4 text bytes.
  - No KEY state; key_out unchanged; cipher_sel=1, decrypt=1.
  - Result streamed back.
- Invalid index: with N_CIPHERS=2, send 05 → one tx byte EE, err=1, return to CMD. A following valid command clears err.
- Timeout: send 01 and 3 key bytes, then idle TIMEOUT_CYCLES → tx EE, err=1. No start pulse.
- Backpressure/noise: hold tx_busy high for 50 cycles in TX, and pulse rx_valid in WAIT.
  - No tx_valid while busy.
  - Stray bytes do not alter text_out.
  - All 4 bytes are still sent.
- Reset mid-TX: assert resetn after byte 1 is sent → all outputs at reset values. The next command runs normally.

Source files
------------

// File: rtl/cipher_uart_ctrl.sv
// Command/response controller between a byte UART pair and a bank of block-cipher cores.
// Parses a command, collects key/block bytes, runs the selected core and streams the result back.
module cipher_uart_ctrl #(
    parameter int         KEY_BYTES      = 8,
    parameter int         BLK_BYTES      = 4,
    parameter int         N_CIPHERS      = 2,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] ERR_CODE       = 8'hEE
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_valid,
    output logic [7:0]             tx_byte,
    output logic                   tx_valid,
    input  logic                   tx_busy,
    input  logic                   tx_done,
    output logic [2:0]             cipher_sel,
    output logic                   decrypt,
    output logic                   start,
    output logic [8*KEY_BYTES-1:0] key_out,
    output logic [8*BLK_BYTES-1:0] text_out,
    input  logic [8*BLK_BYTES-1:0] result_in,
    input  logic                   result_valid,
    output logic [4:0]             state_led,
    output logic                   err
);

    localparam int MAX_BYTES = (KEY_BYTES > BLK_BYTES) ? KEY_BYTES : BLK_BYTES;
    localparam int IDX_W     = $clog2(MAX_BYTES + 1);
    localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] KEY_LAST = IDX_W'(KEY_BYTES - 1);
    localparam logic [IDX_W-1:0] BLK_LAST = IDX_W'(BLK_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       N_CIPH   = 4'(N_CIPHERS);

    typedef enum logic [2:0] {
        S_CMD, S_KEY, S_TEXT, S_START, S_WAIT, S_TX, S_ERR
    } state_e;

    typedef enum logic {
        PH_READY, PH_DONE
    } phase_e;

    state_e                 state_q, state_d;
    phase_e                 phase_q, phase_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;
    logic [8*BLK_BYTES-1:0] text_q, text_d;
    logic [8*BLK_BYTES-1:0] result_q, result_d;
    logic [7:0]             tx_byte_q, tx_byte_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [2:0]             sel_q, sel_d;
    logic                   dec_q, dec_d;
    logic                   start_q, start_d;
    logic                   err_q, err_d;
    logic [4:0]             led_q, led_d;
    logic                   unused_cmd_bits_s;

    assign unused_cmd_bits_s = ^rx_byte[6:4];

    // Next-state, datapath and handshake decisions for the whole controller.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        idx_d      = idx_q;
        to_cnt_d   = '0;
        key_d      = key_q;
        text_d     = text_q;
        result_d   = result_q;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = 1'b0;
        sel_d      = sel_q;
        dec_d      = dec_q;
        start_d    = 1'b0;
        err_d      = err_q;

        case (state_q)
            S_CMD: begin
                if (rx_valid) begin
                    if ({1'b0, rx_byte[3:1]} >= N_CIPH) begin
                        state_d = S_ERR;
                    end else begin
                        sel_d   = rx_byte[3:1];
                        dec_d   = rx_byte[0];
                        err_d   = 1'b0;
                        idx_d   = '0;
                        state_d = rx_byte[7] ? S_TEXT : S_KEY;
                    end
                end else begin
                    idx_d = '0;
                end
            end
            S_KEY: begin
                if (rx_valid) begin
                    for (int i = 0; i < KEY_BYTES; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            key_d[8*i +: 8] = rx_byte;
                        end else begin
                            key_d[8*i +: 8] = key_q[8*i +: 8];
                        end
                    end
                    if (idx_q == KEY_LAST) begin
                        idx_d   = '0;
                        state_d = S_TEXT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    idx_d   = '0;
                    state_d = S_ERR;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_TEXT: begin
                if (rx_valid) begin
                    for (int i = 0; i < BLK_BYTES; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            text_d[8*i +: 8] = rx_byte;
                        end else begin
                            text_d[8*i +: 8] = text_q[8*i +: 8];
                        end
                    end
                    if (idx_q == BLK_LAST) begin
                        idx_d   = '0;
                        state_d = S_START;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    idx_d   = '0;
                    state_d = S_ERR;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_START: begin
                start_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (result_valid) begin
                    result_d = result_in;
                    idx_d    = '0;
                    phase_d  = PH_READY;
                    state_d  = S_TX;
                end else begin
                    result_d = result_q;
                end
            end
            // ERR reuses the byte handshake to send a single error code.
            S_TX, S_ERR: begin
                if (state_q == S_ERR) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (phase_q == PH_READY) begin
                    if (!tx_busy) begin
                        tx_valid_d = 1'b1;
                        tx_byte_d  = (state_q == S_ERR) ? ERR_CODE : result_q[7:0];
                        phase_d    = PH_DONE;
                    end else begin
                        phase_d = PH_READY;
                    end
                end else if (tx_done) begin
                    phase_d = PH_READY;
                    if (state_q == S_ERR || idx_q == BLK_LAST) begin
                        idx_d   = '0;
                        state_d = S_CMD;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        result_d = result_q >> 4'd8;
                    end
                end else begin
                    phase_d = PH_DONE;
                end
            end
            default: begin
                state_d = S_CMD;
                phase_d = PH_READY;
                idx_d   = '0;
            end
        endcase
    end

    // One-hot status LEDs; START shares the WAIT lamp and ERR shares the TX lamp.
    always_comb begin
        case (state_d)
            S_CMD:           led_d = 5'b00001;
            S_KEY:           led_d = 5'b00010;
            S_TEXT:          led_d = 5'b00100;
            S_START, S_WAIT: led_d = 5'b01000;
            S_TX, S_ERR:     led_d = 5'b10000;
            default:         led_d = 5'b00001;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q    <= S_CMD;
            phase_q    <= PH_READY;
            idx_q      <= '0;
            to_cnt_q   <= '0;
            key_q      <= '0;
            text_q     <= '0;
            result_q   <= '0;
            tx_byte_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            sel_q      <= 3'd0;
            dec_q      <= 1'b0;
            start_q    <= 1'b0;
            err_q      <= 1'b0;
            led_q      <= 5'b00001;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            to_cnt_q   <= to_cnt_d;
            key_q      <= key_d;
            text_q     <= text_d;
            result_q   <= result_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            sel_q      <= sel_d;
            dec_q      <= dec_d;
            start_q    <= start_d;
            err_q      <= err_d;
            led_q      <= led_d;
        end
    end

    assign tx_byte    = tx_byte_q;
    assign tx_valid   = tx_valid_q;
    assign cipher_sel = sel_q;
    assign decrypt    = dec_q;
    assign start      = start_q;
    assign key_out    = key_q;
    assign text_out   = text_q;
    assign state_led  = led_q;
    assign err        = err_q;

endmodule

// File: tb/tb_cipher_uart_ctrl.sv
// Self-checking bench for cipher_uart_ctrl: directed scenarios plus randomized command streams
// checked against a byte-array model of key/text/result handling and a transmitter model.
module tb_cipher_uart_ctrl;

    localparam int KB = 8;
    localparam int BB = 4;
    localparam int NC = 2;
    localparam int TO = 40;

    logic            clk = 1'b0;
    logic            resetn = 1'b1;
    logic [7:0]      rx_byte = 8'h00;
    logic            rx_valid = 1'b0;
    logic [7:0]      tx_byte;
    logic            tx_valid;
    logic            tx_busy = 1'b0;
    logic            tx_done = 1'b0;
    logic [2:0]      cipher_sel;
    logic            decrypt;
    logic            start;
    logic [8*KB-1:0] key_out;
    logic [8*BB-1:0] text_out;
    logic [8*BB-1:0] result_in = '0;
    logic            result_valid = 1'b0;
    logic [4:0]      state_led;
    logic            err;

    cipher_uart_ctrl #(
        .KEY_BYTES(KB), .BLK_BYTES(BB), .N_CIPHERS(NC),
        .TIMEOUT_CYCLES(TO), .ERR_CODE(8'hEE)
    ) dut (
        .clk(clk), .resetn(resetn), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_busy(tx_busy), .tx_done(tx_done),
        .cipher_sel(cipher_sel), .decrypt(decrypt), .start(start),
        .key_out(key_out), .text_out(text_out), .result_in(result_in),
        .result_valid(result_valid), .state_led(state_led), .err(err)
    );

    initial forever #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] txq[$];
    int         tx_rd = 0;
    int         busy_cnt = 0;
    int         start_cnt = 0;
    logic [7:0] last_tx = 8'h00;
    bit         hold_busy = 1'b0;

    logic [7:0] mkey[KB];
    logic [7:0] mtext[BB];
    logic [2:0] msel = 3'd0;
    logic       mdec = 1'b0;
    logic       merr = 1'b0;
    logic [7:0] key_src[KB];
    logic [7:0] txt_src[BB];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [8*KB-1:0] pack_key();
        logic [8*KB-1:0] r;
        for (int i = 0; i < KB; i++) r[8*i +: 8] = mkey[i];
        return r;
    endfunction

    function automatic logic [8*BB-1:0] pack_text();
        logic [8*BB-1:0] r;
        for (int i = 0; i < BB; i++) r[8*i +: 8] = mtext[i];
        return r;
    endfunction

    // Transmitter and start-pulse observer: busy for a few cycles after each load, then tx_done.
    initial begin
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (resetn) begin
                busy_cnt = 0;
                tx_busy  = 1'b0;
            end else begin
                if (start) start_cnt++;
                if (tx_valid) begin
                    check_eq("tx_valid_while_busy", 64'(tx_busy), 64'd0);
                    txq.push_back(tx_byte);
                    last_tx  = tx_byte;
                    busy_cnt = $urandom_range(2, 6);
                    tx_busy  = 1'b1;
                end else if (busy_cnt > 0) begin
                    check_eq("tx_byte_stable", 64'(tx_byte), 64'(last_tx));
                    busy_cnt--;
                    if (busy_cnt == 0) begin
                        tx_busy = hold_busy;
                        tx_done = 1'b1;
                    end
                end else begin
                    tx_busy = hold_busy;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic collect_tx(input int n, input logic [31:0] res, input bit is_err);
        int k = 0;
        while (txq.size() < tx_rd + n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check_eq("tx_byte_count", 64'(txq.size() - tx_rd), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (tx_rd < txq.size()) begin
                check_eq("tx_data", 64'(txq[tx_rd]), is_err ? 64'hEE : 64'(res[8*i +: 8]));
                tx_rd++;
            end
        end
    endtask

    task automatic wait_cmd();
        int k = 0;
        while (state_led != 5'b00001 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check_eq("back_to_cmd", 64'(state_led), 64'h01);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_tx_byte"}, 64'(tx_byte), 64'd0);
        check_eq({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
        check_eq({tag, "_sel"}, 64'(cipher_sel), 64'd0);
        check_eq({tag, "_dec"}, 64'(decrypt), 64'd0);
        check_eq({tag, "_start"}, 64'(start), 64'd0);
        check_eq({tag, "_key"}, 64'(key_out), 64'd0);
        check_eq({tag, "_text"}, 64'(text_out), 64'd0);
        check_eq({tag, "_err"}, 64'(err), 64'd0);
        check_eq({tag, "_led"}, 64'(state_led), 64'h01);
    endtask

    task automatic model_reset();
        for (int i = 0; i < KB; i++) mkey[i] = 8'h00;
        for (int i = 0; i < BB; i++) mtext[i] = 8'h00;
        msel = 3'd0;
        mdec = 1'b0;
        merr = 1'b0;
    endtask

    // One full command; long_gap_at picks a text byte preceded by a near-timeout gap.
    task automatic run_cmd(input logic [7:0] cmd, input logic [31:0] res, input bit noise,
                           input bit stall, input int long_gap_at, input int rst_after);
        logic [2:0] ix;
        int         s0;
        ix = cmd[3:1];
        s0 = start_cnt;
        send_byte(cmd);
        if (int'(ix) >= NC) begin
            collect_tx(1, 32'h0, 1'b1);
            wait_cmd();
            merr = 1'b1;
            check_eq("err_set", 64'(err), 64'(merr));
            check_eq("sel_kept", 64'(cipher_sel), 64'(msel));
            check_eq("no_start_on_err", 64'(start_cnt), 64'(s0));
        end else begin
            msel = ix;
            mdec = cmd[0];
            merr = 1'b0;
            hold_busy = stall;
            check_eq("err_clear", 64'(err), 64'(merr));
            check_eq("sel", 64'(cipher_sel), 64'(msel));
            check_eq("dec", 64'(decrypt), 64'(mdec));
            check_eq("led_after_cmd", 64'(state_led), cmd[7] ? 64'h04 : 64'h02);
            if (!cmd[7]) begin
                for (int i = 0; i < KB; i++) begin
                    idle($urandom_range(0, 3));
                    mkey[i] = key_src[i];
                    send_byte(key_src[i]);
                    check_eq("key_byte", 64'(key_out), 64'(pack_key()));
                end
            end
            for (int i = 0; i < BB; i++) begin
                idle((i == long_gap_at) ? TO - 2 : $urandom_range(0, 3));
                mtext[i] = txt_src[i];
                send_byte(txt_src[i]);
                check_eq("text_byte", 64'(text_out), 64'(pack_text()));
            end
            check_eq("key_kept", 64'(key_out), 64'(pack_key()));
            @(negedge clk);
            check_eq("start_pulse", 64'(start), 64'd1);
            @(negedge clk);
            check_eq("start_low", 64'(start), 64'd0);
            check_eq("start_once", 64'(start_cnt), 64'(s0 + 1));
            if (noise) begin
                repeat (3) send_byte(8'($urandom));
                check_eq("noise_text", 64'(text_out), 64'(pack_text()));
            end
            result_in    = res;
            result_valid = 1'b1;
            @(negedge clk);
            result_valid = 1'b0;
            result_in    = 32'($urandom);
            if (noise) repeat (2) send_byte(8'($urandom));
            if (stall) begin
                idle(50);
                check_eq("stall_no_tx", 64'(txq.size() - tx_rd), 64'd0);
                hold_busy = 1'b0;
            end
            collect_tx((rst_after > 0) ? rst_after : BB, res, 1'b0);
            if (rst_after > 0) begin
                resetn = 1'b1;
                @(negedge clk);
                check_reset_vals("mid_tx_reset");
                @(negedge clk);
                resetn = 1'b0;
                model_reset();
                @(negedge clk);
                tx_rd = txq.size();
            end else begin
                wait_cmd();
                check_eq("text_final", 64'(text_out), 64'(pack_text()));
                check_eq("key_final", 64'(key_out), 64'(pack_key()));
                check_eq("err_final", 64'(err), 64'(merr));
                check_eq("one_start_total", 64'(start_cnt), 64'(s0 + 1));
            end
        end
    endtask

    initial begin
        logic [7:0] k1[KB];
        logic [7:0] t1[BB];
        logic [7:0] cmd;
        int         s0;
        int         lg;
        k1 = '{8'h00, 8'h01, 8'h08, 8'h09, 8'h10, 8'h11, 8'h18, 8'h19};
        t1 = '{8'h65, 8'h65, 8'h77, 8'h68};
        model_reset();
        idle(3);
        check_reset_vals("in_reset");
        resetn = 1'b0;
        @(negedge clk);
        check_reset_vals("after_reset");

        // Test-plan vector on cipher 0.
        key_src = k1;
        txt_src = t1;
        run_cmd(8'h01, 32'he9bbc69b, 1'b0, 1'b0, -1, 0);
        check_eq("tp_key", 64'(key_out), 64'h1918111009080100);
        check_eq("tp_text", 64'(text_out), 64'h68776565);

        // Key reuse on cipher 1, decrypt.
        txt_src = '{8'hde, 8'had, 8'hbe, 8'hef};
        run_cmd(8'h83, 32'h01234567, 1'b0, 1'b0, -1, 0);
        check_eq("reuse_key", 64'(key_out), 64'h1918111009080100);
        check_eq("reuse_sel", 64'(cipher_sel), 64'd1);
        check_eq("reuse_dec", 64'(decrypt), 64'd1);

        // Out-of-range cipher index.
        run_cmd(8'h05, 32'h0, 1'b0, 1'b0, -1, 0);

        // Inter-byte timeout during key collection.
        s0 = start_cnt;
        send_byte(8'h01);
        msel = 3'd0;
        mdec = 1'b1;
        merr = 1'b0;
        check_eq("to_err_clear", 64'(err), 64'(merr));
        for (int i = 0; i < 3; i++) begin
            mkey[i] = 8'hA0 + 8'(i);
            send_byte(mkey[i]);
        end
        collect_tx(1, 32'h0, 1'b1);
        wait_cmd();
        merr = 1'b1;
        check_eq("to_err", 64'(err), 64'(merr));
        check_eq("to_no_start", 64'(start_cnt), 64'(s0));
        check_eq("to_partial_key", 64'(key_out), 64'(pack_key()));

        // Backpressure with stray receive bytes.
        for (int i = 0; i < KB; i++) key_src[i] = 8'($urandom);
        for (int i = 0; i < BB; i++) txt_src[i] = 8'($urandom);
        run_cmd(8'h02, 32'($urandom), 1'b1, 1'b1, -1, 0);

        // Reset in the middle of the response, then a normal command.
        run_cmd(8'h00, 32'hcafef00d, 1'b0, 1'b0, -1, 2);
        for (int i = 0; i < BB; i++) txt_src[i] = 8'($urandom);
        run_cmd(8'h80, 32'h5a5aa5a5, 1'b0, 1'b0, -1, 0);

        // Randomized command stream.
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < KB; i++) key_src[i] = 8'($urandom);
            for (int i = 0; i < BB; i++) txt_src[i] = 8'($urandom);
            cmd = 8'($urandom);
            if ($urandom_range(0, 5) == 0) cmd[3:1] = 3'($urandom_range(NC, 7));
            else cmd[3:1] = 3'($urandom_range(0, NC - 1));
            lg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BB - 1)) : -1;
            run_cmd(cmd, 32'($urandom), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0), lg, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
